// File: rtl/spi_pkg.sv
// Shared SPI master definitions: FSM state type, SPI mode decode and the
// number of SCK edges in a one-byte transfer.
package spi_pkg;

  // Controller states: waiting for a request, or shifting a byte.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } spi_state_t;

  // One byte moves in 8 full SCK periods = 16 edges.
  localparam int unsigned SPI_EDGES = 16;

  // Clock polarity / phase pair derived from the classic SPI mode number.
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Mode 0: CPOL=0 CPHA=0, mode 1: 0/1, mode 2: 1/0, mode 3: 1/1.
  function automatic spi_mode_t decode_mode(input int unsigned mode);
    spi_mode_t cfg;
    cfg.cpol = (mode == 2) || (mode == 3);
    cfg.cpha = (mode == 1) || (mode == 3);
    return cfg;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK generator: divides clk into SCK half-periods, counts the 16 edges of a
// transfer and flags whether each edge is a leading or a trailing one.
// Strobes are asserted in the cycle whose rising clk edge toggles SCK, so the
// datapath acts on exactly the same clk edge that moves SCK.
module spi_sck_gen
  import spi_pkg::*;
#(
  parameter logic CPOL              = 1'b0,
  parameter int   CLKS_PER_HALF_BIT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,     // high while a transfer is in progress
  output logic o_sck,        // registered SCK
  output logic o_lead,       // this edge is an odd (leading) edge
  output logic o_trail,      // this edge is an even (trailing) edge
  output logic o_last_edge,  // this edge is edge 16
  output logic o_done        // all 16 edges have been produced
);

  localparam int         CW        = $clog2(CLKS_PER_HALF_BIT);
  localparam logic [CW-1:0] HALF_MAX = CW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [4:0] EDGE_LAST = 5'(SPI_EDGES);

  logic [CW-1:0] r_half_cnt;
  logic [4:0]    r_edge_cnt;
  logic          r_sck;
  logic          w_tick;

  // A tick is the end of a half-period while edges remain to be produced.
  assign w_tick      = i_active && (r_edge_cnt != EDGE_LAST) && (r_half_cnt == HALF_MAX);
  // r_edge_cnt holds edges already produced, so an even count means the
  // upcoming edge number is odd (leading).
  assign o_lead      = w_tick && !r_edge_cnt[0];
  assign o_trail     = w_tick &&  r_edge_cnt[0];
  assign o_last_edge = w_tick && (r_edge_cnt == EDGE_LAST - 5'd1);
  assign o_done      = i_active && (r_edge_cnt == EDGE_LAST);
  assign o_sck       = r_sck;

  // Half-bit divider, edge counter and SCK toggle; everything parks at the
  // idle level whenever no transfer is active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_half_cnt <= '0;
      r_edge_cnt <= '0;
      r_sck      <= CPOL;
    end else if (!i_active) begin
      r_half_cnt <= '0;
      r_edge_cnt <= '0;
      r_sck      <= CPOL;
    end else if (w_tick) begin
      r_half_cnt <= '0;
      r_edge_cnt <= r_edge_cnt + 5'd1;
      r_sck      <= ~r_sck;
    end else if (r_edge_cnt != EDGE_LAST) begin
      r_half_cnt <= r_half_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// SPI master, one byte per request, MSB first, selectable SPI mode 0..3.
// Handshake: a request is taken when i_MOSI_DV meets o_MOSI_Ready; the
// received byte is presented with a one-cycle o_MISO_DV pulse in the same
// cycle Ready returns high, so back-to-back bytes cost one idle cycle.
module spi_master
  import spi_pkg::*;
#(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] i_MOSI_Byte,
  input  logic       i_MOSI_DV,
  output logic       o_MOSI_Ready,
  output logic       o_MISO_DV,
  output logic [7:0] o_MISO_Byte,
  output logic       SCK,
  input  logic       MISO,
  output logic       MOSI
);

  localparam spi_mode_t MODE_CFG = decode_mode(SPI_MODE);
  localparam logic      CPOL     = MODE_CFG.cpol;
  localparam logic      CPHA     = MODE_CFG.cpha;

  spi_state_t r_state;
  spi_state_t w_state_next;
  logic       w_ready_next;
  logic       w_miso_dv_next;

  logic       r_ready;
  logic       r_miso_dv;
  logic [7:0] r_miso_byte;
  logic [7:0] r_tx_shift;
  logic [7:0] r_rx_shift;
  logic       r_mosi;

  logic       w_accept;
  logic       w_active;
  logic       w_lead;
  logic       w_trail;
  logic       w_last_edge;
  logic       w_done;
  logic       w_shift_out;
  logic       w_sample;
  logic       w_sck;

  assign w_active = (r_state == ST_XFER);
  assign w_accept = (r_state == ST_IDLE) && r_ready && i_MOSI_DV;

  // CPHA=0 presents bit 7 up front, samples on leading edges and advances on
  // trailing edges (none after the final edge). CPHA=1 advances on leading
  // edges and samples on trailing edges.
  assign w_shift_out = CPHA ? w_lead : (w_trail && !w_last_edge);
  assign w_sample    = CPHA ? w_trail : w_lead;

  spi_sck_gen #(
    .CPOL              (CPOL),
    .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT)
  ) u_sck_gen (
    .clk         (clk),
    .rst         (rst),
    .i_active    (w_active),
    .o_sck       (w_sck),
    .o_lead      (w_lead),
    .o_trail     (w_trail),
    .o_last_edge (w_last_edge),
    .o_done      (w_done)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state plus the next values of the registered handshake outputs.
  always_comb begin
    w_state_next   = r_state;
    w_miso_dv_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_XFER;
        end
      end
      ST_XFER: begin
        if (w_done) begin
          w_state_next   = ST_IDLE;
          w_miso_dv_next = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    // Ready tracks the state we are about to be in, which also makes it rise
    // on the first clock after reset is released.
    w_ready_next = (w_state_next == ST_IDLE);
  end

  // Shift registers, MOSI driver and handshake outputs. MISO is sampled
  // directly on the SCK-moving clk edge so a MOSI->MISO loopback lines up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready     <= 1'b0;
      r_miso_dv   <= 1'b0;
      r_miso_byte <= 8'h00;
      r_tx_shift  <= 8'h00;
      r_rx_shift  <= 8'h00;
      r_mosi      <= 1'b0;
    end else begin
      r_ready   <= w_ready_next;
      r_miso_dv <= w_miso_dv_next;
      if (w_miso_dv_next) begin
        r_miso_byte <= r_rx_shift;
      end
      if (w_accept) begin
        r_rx_shift <= 8'h00;
        if (!CPHA) begin
          r_mosi     <= i_MOSI_Byte[7];
          r_tx_shift <= {i_MOSI_Byte[6:0], 1'b0};
        end else begin
          r_tx_shift <= i_MOSI_Byte;
        end
      end else if (w_active) begin
        if (w_shift_out) begin
          r_mosi     <= r_tx_shift[7];
          r_tx_shift <= {r_tx_shift[6:0], 1'b0};
        end
        if (w_sample) begin
          r_rx_shift <= {r_rx_shift[6:0], MISO};
        end
      end
    end
  end

  assign o_MOSI_Ready = r_ready;
  assign o_MISO_DV    = r_miso_dv;
  assign o_MISO_Byte  = r_miso_byte;
  assign SCK          = w_sck;
  assign MOSI         = r_mosi;

endmodule

// File: tb/tb_spi_master.sv
// Testbench for spi_master: four instances (modes 0..3, differing half-bit
// dividers) exercised with loopback and a mode-0 slave model.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_byte [4];
  logic       tx_dv   [4];
  logic       ready   [4];
  logic       rx_dv   [4];
  logic [7:0] rx_byte [4];
  logic       sck     [4];
  logic       mosi    [4];
  logic       miso    [4];

  int checks   = 0;
  int failures = 0;

  // Mode-0 slave model on instance 0: presents the pattern MSB first, shifts
  // on falling SCK, captures MOSI on rising SCK.
  logic       use_slave = 1'b0;
  logic       slave_clr = 1'b0;
  int         slave_cnt = 0;
  logic [7:0] slave_pat = 8'h5A;
  logic [7:0] slave_rx  = 8'h00;
  logic       slave_bit;

  always #5 clk = ~clk;

  // Instance m uses SPI mode m; the half-bit divider differs per instance.
  function automatic int hp_of(input int m);
    return (m == 3) ? 4 : ((m == 1) ? 3 : 2);
  endfunction

  function automatic logic cpol_of(input int m);
    return (m >= 2);
  endfunction

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
      localparam int HP = (gi == 3) ? 4 : ((gi == 1) ? 3 : 2);
      spi_master #(
        .SPI_MODE          (gi),
        .CLKS_PER_HALF_BIT (HP)
      ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_MOSI_Byte  (tx_byte[gi]),
        .i_MOSI_DV    (tx_dv[gi]),
        .o_MOSI_Ready (ready[gi]),
        .o_MISO_DV    (rx_dv[gi]),
        .o_MISO_Byte  (rx_byte[gi]),
        .SCK          (sck[gi]),
        .MISO         (miso[gi]),
        .MOSI         (mosi[gi])
      );
      if (gi == 0) begin : g_miso0
        assign miso[gi] = use_slave ? slave_bit : mosi[gi];
      end else begin : g_misoN
        assign miso[gi] = mosi[gi];
      end
    end
  endgenerate

  assign slave_bit = (slave_cnt < 8) ? slave_pat[3'(7 - slave_cnt)] : 1'b0;

  always @(negedge sck[0] or posedge slave_clr) begin
    if (slave_clr) slave_cnt <= 0;
    else if (slave_cnt < 8) slave_cnt <= slave_cnt + 1;
  end

  always @(posedge sck[0]) begin
    slave_rx <= {slave_rx[6:0], mosi[0]};
  end

  // Issue one byte on instance m as soon as Ready is seen (at a negedge) and
  // observe the transfer until Ready returns. inject_at >= 0 pulses a 0xFF
  // request that many cycles into the transfer.
  task automatic run_xfer(input int m, input logic [7:0] b, input int inject_at,
                          output logic [7:0] got, output int low_cycles,
                          output int dv_cnt, output int toggles,
                          output logic b7_ok, output logic timed_out);
    logic prev;
    logic done;
    int   w;
    got = 8'h00; low_cycles = 0; dv_cnt = 0; toggles = 0;
    b7_ok = 1'b1; timed_out = 1'b0; done = 1'b0;
    w = 0;
    while (ready[m] !== 1'b1 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (ready[m] !== 1'b1) begin
      timed_out = 1'b1;
    end else begin
      tx_byte[m] = b;
      tx_dv[m]   = 1'b1;
      prev       = sck[m];
      @(negedge clk);
      w = 0;
      while (!done && w < 300) begin
        tx_dv[m] = (w == inject_at);
        if (w == inject_at) tx_byte[m] = 8'hFF;
        if (rx_dv[m] === 1'b1) dv_cnt++;
        if (sck[m] !== prev) begin
          toggles++;
          prev = sck[m];
        end
        if (toggles == 0 && mosi[m] !== b[7]) b7_ok = 1'b0;
        if (ready[m] === 1'b1) begin
          got  = rx_byte[m];
          done = 1'b1;
        end else begin
          low_cycles++;
          @(negedge clk);
          w++;
        end
      end
      if (!done) timed_out = 1'b1;
      tx_dv[m] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int m = 0; m < 4; m++) begin
      tx_dv[m]   = 1'b0;
      tx_byte[m] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (sck[m] !== cpol_of(m) || mosi[m] !== 1'b0 || ready[m] !== 1'b0 ||
          rx_dv[m] !== 1'b0 || rx_byte[m] !== 8'h00) begin
        failures++;
        $display("FAIL reset_state m=%0d got sck=%b mosi=%b rdy=%b dv=%b byte=%h want sck=%b mosi=0 rdy=0 dv=0 byte=00",
                 m, sck[m], mosi[m], ready[m], rx_dv[m], rx_byte[m], cpol_of(m));
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      checks++;
      if (ready[m] !== 1'b1) begin
        failures++;
        $display("FAIL ready_after_reset m=%0d got %b want 1", m, ready[m]);
      end
    end
  endtask

  // Check one observed transfer against the expected timing and data.
  // Each scenario below inlines this comparison set for its own transfers.
  task automatic test_mode3_single();
    logic [7:0] got; int low, dvc, tg; logic b7, to;
    run_xfer(3, 8'h37, -1, got, low, dvc, tg, b7, to);
    checks++;
    if (to || got !== 8'h37 || dvc != 1 || low != 65 || tg != 16) begin
      failures++;
      $display("FAIL mode3_single got to=%b byte=%h dv=%0d low=%0d edges=%0d want to=0 byte=37 dv=1 low=65 edges=16",
               to, got, dvc, low, tg);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (rx_dv[3] !== 1'b0 || sck[3] !== 1'b1 || mosi[3] !== 1'b1 || ready[3] !== 1'b1) begin
      failures++;
      $display("FAIL mode3_idle got dv=%b sck=%b mosi=%b rdy=%b want dv=0 sck=1 mosi=1 rdy=1",
               rx_dv[3], sck[3], mosi[3], ready[3]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat [2];
    logic [7:0] got; int low, dvc, tg; logic b7, to;
    pat[0] = 8'h38;
    pat[1] = 8'h39;
    for (int i = 0; i < 2; i++) begin
      run_xfer(3, pat[i], -1, got, low, dvc, tg, b7, to);
      checks++;
      if (to || got !== pat[i] || dvc != 1 || low != 65 || tg != 16) begin
        failures++;
        $display("FAIL back_to_back[%0d] got to=%b byte=%h dv=%0d low=%0d edges=%0d want byte=%h dv=1 low=65 edges=16",
                 i, to, got, dvc, low, tg, pat[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (rx_dv[3] !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_dv_width got %b want 0", rx_dv[3]);
    end
  endtask

  task automatic test_modes_loopback();
    logic [7:0] pat [6];
    logic [7:0] got; int low, dvc, tg; logic b7, to;
    pat[0] = 8'hA5; pat[1] = 8'h00; pat[2] = 8'hFF;
    pat[3] = 8'($urandom); pat[4] = 8'($urandom); pat[5] = 8'($urandom);
    for (int m = 0; m < 3; m++) begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (sck[m] !== cpol_of(m)) begin
          failures++;
          $display("FAIL sck_idle_before m=%0d got %b want %b", m, sck[m], cpol_of(m));
        end
        run_xfer(m, pat[i], -1, got, low, dvc, tg, b7, to);
        checks++;
        if (to || got !== pat[i] || dvc != 1 || low != 16 * hp_of(m) + 1 || tg != 16) begin
          failures++;
          $display("FAIL loopback m=%0d got to=%b byte=%h dv=%0d low=%0d edges=%0d want byte=%h dv=1 low=%0d edges=16",
                   m, to, got, dvc, low, tg, pat[i], 16 * hp_of(m) + 1);
        end
        @(negedge clk);
        checks++;
        if (sck[m] !== cpol_of(m) || mosi[m] !== pat[i][0]) begin
          failures++;
          $display("FAIL idle_after m=%0d got sck=%b mosi=%b want sck=%b mosi=%b",
                   m, sck[m], mosi[m], cpol_of(m), pat[i][0]);
        end
      end
    end
  endtask

  task automatic test_slave_mode0();
    logic [7:0] b;
    logic [7:0] got; int low, dvc, tg; logic b7, to;
    b = 8'($urandom_range(0, 255)) | 8'h80;
    use_slave = 1'b1;
    slave_clr = 1'b1;
    #1 slave_clr = 1'b0;
    @(negedge clk);
    run_xfer(0, b, -1, got, low, dvc, tg, b7, to);
    checks++;
    if (to || got !== 8'h5A || dvc != 1) begin
      failures++;
      $display("FAIL slave_miso got to=%b byte=%h dv=%0d want byte=5a dv=1", to, got, dvc);
    end
    checks++;
    if (!b7) begin
      failures++;
      $display("FAIL slave_mosi_bit7_setup got unstable want MOSI=%b before first edge", b[7]);
    end
    checks++;
    if (slave_rx !== b) begin
      failures++;
      $display("FAIL slave_mosi_byte got %h want %h", slave_rx, b);
    end
    use_slave = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ignored_dv();
    logic [7:0] got; int low, dvc, tg; logic b7, to;
    run_xfer(3, 8'h37, 20, got, low, dvc, tg, b7, to);
    checks++;
    if (to || got !== 8'h37 || dvc != 1 || low != 65 || tg != 16) begin
      failures++;
      $display("FAIL ignored_dv got to=%b byte=%h dv=%0d low=%0d edges=%0d want byte=37 dv=1 low=65 edges=16",
               to, got, dvc, low, tg);
    end
    dvc = 0; low = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rx_dv[3] === 1'b1) dvc++;
      if (ready[3] !== 1'b1) low++;
    end
    checks++;
    if (dvc != 0 || low != 0) begin
      failures++;
      $display("FAIL ignored_dv_not_queued got dv=%0d busy=%0d want 0 0", dvc, low);
    end
  endtask

  task automatic test_reset_abort();
    int tg, w, dvc;
    logic prev;
    logic [7:0] got; int low, dvc2, tg2; logic b7, to;
    tg = 0; w = 0; dvc = 0;
    tx_byte[3] = 8'hE7;
    tx_dv[3]   = 1'b1;
    prev       = sck[3];
    @(negedge clk);
    tx_dv[3] = 1'b0;
    while (tg < 8 && w < 300) begin
      if (rx_dv[3] === 1'b1) dvc++;
      if (sck[3] !== prev) begin tg++; prev = sck[3]; end
      if (tg < 8) begin @(negedge clk); w++; end
    end
    checks++;
    if (tg != 8) begin
      failures++;
      $display("FAIL abort_reach_edge8 got %0d edges want 8", tg);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (sck[3] !== 1'b1 || mosi[3] !== 1'b0 || ready[3] !== 1'b0 ||
        rx_dv[3] !== 1'b0 || rx_byte[3] !== 8'h00) begin
      failures++;
      $display("FAIL abort_async got sck=%b mosi=%b rdy=%b dv=%b byte=%h want 1 0 0 0 00",
               sck[3], mosi[3], ready[3], rx_dv[3], rx_byte[3]);
    end
    repeat (2) begin
      @(negedge clk);
      if (rx_dv[3] === 1'b1) dvc++;
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rx_dv[3] === 1'b1) dvc++;
    end
    checks++;
    if (dvc != 0 || rx_byte[3] !== 8'h00 || ready[3] !== 1'b1) begin
      failures++;
      $display("FAIL abort_no_dv got dv=%0d byte=%h rdy=%b want 0 00 1", dvc, rx_byte[3], ready[3]);
    end
    run_xfer(3, 8'hC3, -1, got, low, dvc2, tg2, b7, to);
    checks++;
    if (to || got !== 8'hC3 || dvc2 != 1 || low != 65 || tg2 != 16) begin
      failures++;
      $display("FAIL after_abort got to=%b byte=%h dv=%0d low=%0d edges=%0d want byte=c3 dv=1 low=65 edges=16",
               to, got, dvc2, low, tg2);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int m, n;
    logic [7:0] b;
    logic [7:0] got; int low, dvc, tg; logic b7, to;
    for (int t = 0; t < 16; t++) begin
      m = int'($urandom_range(0, 3));
      n = int'($urandom_range(1, 3));
      b = 8'h00;
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        run_xfer(m, b, -1, got, low, dvc, tg, b7, to);
        checks++;
        if (to || got !== b || dvc != 1 || low != 16 * hp_of(m) + 1 || tg != 16) begin
          failures++;
          $display("FAIL random m=%0d got to=%b byte=%h dv=%0d low=%0d edges=%0d want byte=%h dv=1 low=%0d edges=16",
                   m, to, got, dvc, low, tg, b, 16 * hp_of(m) + 1);
        end
      end
      @(negedge clk);
      checks++;
      if (sck[m] !== cpol_of(m) || mosi[m] !== b[0] || rx_dv[m] !== 1'b0) begin
        failures++;
        $display("FAIL random_idle m=%0d got sck=%b mosi=%b dv=%b want sck=%b mosi=%b dv=0",
                 m, sck[m], mosi[m], rx_dv[m], cpol_of(m), b[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode3_single();
    test_back_to_back();
    test_modes_loopback();
    test_slave_mode0();
    test_ignored_dv();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter SPI_MODE, default 0, SPI mode 0..3; CPOL = mode 2 or 3, CPHA = mode 1 or 3.
REQ-002 Parameter CLKS_PER_HALF_BIT, default 2, clk cycles per SCK half-period; legal range >= 2.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 i_MOSI_Byte  input  8  byte to transmit, sampled when i_MOSI_DV accepted.
REQ-006 i_MOSI_DV  input  1  one-cycle transmit request.
REQ-007 o_MOSI_Ready  output  1  high when idle and able to accept a request.
REQ-008 o_MISO_DV  output  1  one-cycle pulse, received byte valid.
REQ-009 o_MISO_Byte  output  8  last received byte, held until next completion.
REQ-010 SCK  output  1  SPI serial clock.
REQ-011 MISO  input  1  serial data in.
REQ-012 MOSI  output  1  serial data out.

Function
REQ-013 States: IDLE (Ready=1, SCK=CPOL) and XFER (Ready=0); no other states.
REQ-014 Request accepted only when i_MOSI_DV=1 and o_MOSI_Ready=1 on the same clk edge (T0); DV while Ready=0 is ignored, not queued.
REQ-015 On acceptance, byte latched internally; o_MOSI_Ready low from T0+1 until completion.
REQ-016 Transfer = exactly 16 SCK edges; edge k (k=1..16) appears on SCK at T0+k*CLKS_PER_HALF_BIT; SCK returns to CPOL after edge 16.
REQ-017 Bit order MSB first on both MOSI and MISO.
REQ-018 CPHA=0: MOSI bit 7 driven by T0+1 (before first edge); MISO sampled on odd edges (leading); MOSI advances on even edges (trailing), except after edge 16.
REQ-019 CPHA=1: MOSI shifts to next bit on odd edges (leading), bit 7 on edge 1; MISO sampled on even edges (trailing).
REQ-020 MOSI holds last driven bit when idle.
REQ-021 Completion at T0+16*CLKS_PER_HALF_BIT+1: o_MISO_Byte updated with the 8 sampled bits, o_MISO_DV high for exactly that one cycle, o_MOSI_Ready returns high in the same cycle.
REQ-022 o_MISO_Byte is valid no later than the rising edge of o_MOSI_Ready.
REQ-023 New request accepted on the cycle Ready is high after completion; back-to-back bytes need no idle gap beyond one cycle.
REQ-024 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-025 While rst high: SCK=CPOL, MOSI=0, o_MOSI_Ready=0, o_MISO_DV=0, o_MISO_Byte=0x00, counters cleared, state IDLE.
REQ-026 o_MOSI_Ready rises on the first clk edge after rst deasserts.
REQ-027 Reset mid-transfer aborts immediately; no o_MISO_DV pulse, partial byte discarded.

Structure
REQ-028 Package spi_pkg holds the state enum, the CPOL/CPHA decode function from SPI_MODE, and the edge-count constant 16.
REQ-029 One sub-module spi_sck_gen: half-bit counter, edge counter, SCK register, leading/trailing edge strobes; spi_master holds shift registers and handshake.

Verification
REQ-030 Loopback MISO=MOSI, mode 3, CLKS_PER_HALF_BIT=4: send 0x37 -> o_MISO_DV pulse once, o_MISO_Byte=0x37 at Ready rise, Ready low for 65 cycles.
REQ-031 Same loopback, back-to-back 0x38 then 0x39 issued on Ready -> received 0x38 then 0x39, two DV pulses.
REQ-032 Modes 0,1,2 loopback with 0xA5 and 0x00/0xFF -> echo exact; SCK idle level = CPOL before and after.
REQ-033 Mode 0, MISO driven by a slave model returning 0x5A -> o_MISO_Byte=0x5A; MOSI bit 7 stable before first SCK edge.
REQ-034 DV pulsed while Ready=0 with 0xFF during 0x37 transfer -> ignored, only 0x37 sent, single DV pulse.
REQ-035 rst asserted at edge 8 of a transfer -> outputs at reset values asynchronously, no o_MISO_DV; next request after release completes normally.
